// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side sequencer for the 8x16 register file.
// Buffers writeback requests in a small FIFO and strobes the regfile write port
// whenever the reader leaves address_a free (rf_busy_i low). Per-register pending
// flags expose queued or in-flight writes so decode can stall on RAW hazards.
//
// Optional build macro:
//   WB_BYPASS_EN - adds a combinational forwarding port (byp_addr_i/byp_hit_o/
//                  byp_data_o) returning the youngest queued or strobing value.

module regfile_writeback #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // Writeback request from execute
    input  logic                     wb_valid_i,
    output logic                     wb_ready_o,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    // Regfile write port
    input  logic                     rf_busy_i,
    output logic                     rf_write_enable_o,
    output logic [ADDR_W-1:0]        rf_address_o,
    output logic [DATA_W-1:0]        rf_write_data_o,
    // Hazard / status
    output logic [2**ADDR_W-1:0]     pending_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]        byp_addr_i,
    output logic                     byp_hit_o,
    output logic [DATA_W-1:0]        byp_data_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 2**ADDR_W;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } state_e;

    state_e              state_q, state_d;

    logic [ADDR_W-1:0]   fifo_addr_q [DEPTH];
    logic [DATA_W-1:0]   fifo_data_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;

    logic                push;
    logic                pop;
    logic [DEPTH-1:0]    occupied;
    logic [NREG-1:0]     pending;

    // Ready depends on registered count only, so a pop in the same cycle does
    // not open a slot; this keeps valid/busy off the ready path.
    assign wb_ready_o = (count_q < CNT_W'(DEPTH));
    assign push       = wb_valid_i & wb_ready_o;
    // The same load condition applies in both states: rf_busy_i is only
    // looked at on the edge that loads the next head.
    assign pop        = (count_q != '0) & ~rf_busy_i;

    // Occupancy count and pointer advance
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO pointers, count and entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= wb_addr_i;
                fifo_data_q[wr_ptr_q] <= wb_data_i;
            end
        end
    end

    // Next-state logic: load the head into the write-port registers on pop
    always_comb begin
        state_d   = state_q;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // The current strobe always completes; chain the next one
                // directly for one write per cycle.
                state_d = pop ? StIssue : StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            rf_addr_d = fifo_addr_q[rd_ptr_q];
            rf_data_d = fifo_data_q[rd_ptr_q];
        end
    end

    // State and write-port registers; address/data hold their last value in idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_write_enable_o = (state_q == StIssue);
    assign rf_address_o      = rf_addr_q;
    assign rf_write_data_o   = rf_data_q;
    assign count_o           = count_q;

    // Slot i is live when its distance from the read pointer is below count
    always_comb begin
        occupied = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [PTR_W-1:0] off;
            off         = PTR_W'(i) - rd_ptr_q;
            occupied[i] = ({1'b0, off} < count_q);
        end
    end

    // Pending flags: any live entry or the in-flight strobe targeting reg r
    always_comb begin
        pending = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (occupied[i]) begin
                pending[fifo_addr_q[i]] = 1'b1;
            end
        end
        if (state_q == StIssue) begin
            pending[rf_addr_q] = 1'b1;
        end
    end

    assign pending_o = pending;

`ifdef WB_BYPASS_EN
    // Forwarding: scan oldest to youngest so the youngest match overrides,
    // starting from the strobe which is older than anything still queued.
    always_comb begin
        logic [PTR_W-1:0] idx;
        byp_hit_o  = 1'b0;
        byp_data_o = '0;
        idx        = '0;
        if ((state_q == StIssue) && (rf_addr_q == byp_addr_i)) begin
            byp_hit_o  = 1'b1;
            byp_data_o = rf_data_q;
        end
        for (int a = 0; a < int'(DEPTH); a++) begin
            idx = rd_ptr_q + PTR_W'(a);
            if ((CNT_W'(a) < count_q) && (fifo_addr_q[idx] == byp_addr_i)) begin
                byp_hit_o  = 1'b1;
                byp_data_o = fifo_data_q[idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
// Includes a behavioural regfile fed by the write port. Define WB_BYPASS_EN to
// exercise the forwarding port as well.

module tb_regfile_writeback;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        rf_busy;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_wdata;
    logic [7:0]  pending;
    logic [2:0]  count;
`ifdef WB_BYPASS_EN
    logic [2:0]  byp_addr;
    logic        byp_hit;
    logic [15:0] byp_data;
`endif

    logic [15:0] rf_mem [8];
    int          n_commits;
    int          n_checks;
    int          n_pass;

    regfile_writeback #(
        .DATA_W(16),
        .ADDR_W(3),
        .DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wb_valid_i       (wb_valid),
        .wb_ready_o       (wb_ready),
        .wb_addr_i        (wb_addr),
        .wb_data_i        (wb_data),
        .rf_busy_i        (rf_busy),
        .rf_write_enable_o(rf_we),
        .rf_address_o     (rf_addr),
        .rf_write_data_o  (rf_wdata),
        .pending_o        (pending),
        .count_o          (count)
`ifdef WB_BYPASS_EN
        ,
        .byp_addr_i       (byp_addr),
        .byp_hit_o        (byp_hit),
        .byp_data_o       (byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural regfile: commits on the edge that ends a strobe cycle
    initial begin
        for (int i = 0; i < 8; i++) rf_mem[i] = '0;
        n_commits = 0;
    end
    always @(posedge clk) begin
        if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
            n_commits       <= n_commits + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [2:0] a, input logic [15:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    int base;
    logic [2:0] exp_a;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        rf_busy  = 1'b0;
`ifdef WB_BYPASS_EN
        byp_addr = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_we", 32'(rf_we), 32'd0);
        check_eq("rst_ready", 32'(wb_ready), 32'd1);
        check_eq("rst_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;

        // Single write r5 <= BEEF
        push(3'd5, 16'hBEEF);
        check_eq("t2_count_q", 32'(count), 32'd1);
        check_eq("t2_pend_q", 32'(pending), 32'h20);
        check_eq("t2_we_lat", 32'(rf_we), 32'd0);
        tick();
        check_eq("t2_we", 32'(rf_we), 32'd1);
        check_eq("t2_addr", 32'(rf_addr), 32'd5);
        check_eq("t2_data", 32'(rf_wdata), 32'hBEEF);
        check_eq("t2_pend_s", 32'(pending), 32'h20);
        check_eq("t2_count_s", 32'(count), 32'd0);
        tick();
        check_eq("t2_we_off", 32'(rf_we), 32'd0);
        check_eq("t2_pend_clr", 32'(pending), 32'd0);
        check_eq("t2_rf5", 32'(rf_mem[5]), 32'hBEEF);
        check_eq("t2_addr_hold", 32'(rf_addr), 32'd5);

        // WAW: r2 <= 0001 then r2 <= 0002 back to back
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h0001;
        tick();
        wb_data = 16'h0002;
        check_eq("t4_pend_a", 32'(pending[2]), 32'd1);
        tick();
        wb_valid = 1'b0;
        check_eq("t4_we1", 32'(rf_we), 32'd1);
        check_eq("t4_data1", 32'(rf_wdata), 32'h0001);
        check_eq("t4_pend_b", 32'(pending[2]), 32'd1);
        tick();
        check_eq("t4_we2", 32'(rf_we), 32'd1);
        check_eq("t4_data2", 32'(rf_wdata), 32'h0002);
        check_eq("t4_rf2_mid", 32'(rf_mem[2]), 32'h0001);
        check_eq("t4_pend_c", 32'(pending[2]), 32'd1);
        tick();
        check_eq("t4_we_off", 32'(rf_we), 32'd0);
        check_eq("t4_pend_clr", 32'(pending[2]), 32'd0);
        check_eq("t4_rf2", 32'(rf_mem[2]), 32'h0002);

        // Fill with rf_busy high: fifth request refused
        rf_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wb_valid = 1'b1;
            wb_addr  = 3'(k + 1);
            wb_data  = 16'h1000 + 16'(k);
            #1;
            check_eq("t3_ready", 32'(wb_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        wb_valid = 1'b0;
        check_eq("t3_count_full", 32'(count), 32'd4);
        check_eq("t3_we_busy", 32'(rf_we), 32'd0);
        base    = n_commits;
        rf_busy = 1'b0;
        wb_valid = 1'b1; wb_addr = 3'd7; wb_data = 16'hDEAD;
        #1;
        check_eq("t3_ready_full_pop", 32'(wb_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            wb_valid = 1'b0;
            check_eq("t3_we", 32'(rf_we), 32'd1);
            check_eq("t3_addr", 32'(rf_addr), 32'(k + 1));
            check_eq("t3_data", 32'(rf_wdata), 32'h1000 + 32'(k));
        end
        tick();
        check_eq("t3_we_off", 32'(rf_we), 32'd0);
        check_eq("t3_count0", 32'(count), 32'd0);
        check_eq("t3_commits", 32'(n_commits - base), 32'd4);
        check_eq("t3_rf5", 32'(rf_mem[5]), 32'hBEEF);
        check_eq("t3_rf7", 32'(rf_mem[7]), 32'h0000);

        // rf_busy toggling with three queued
        rf_busy = 1'b1;
        push(3'd4, 16'h00A1);
        push(3'd5, 16'h00A2);
        push(3'd6, 16'h00A3);
        base  = n_commits;
        exp_a = 3'd4;
        for (int k = 0; k < 7; k++) begin
            rf_busy = (k % 2 == 0);
            tick();
            check_eq("t5_we", 32'(rf_we), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (rf_we) begin
                check_eq("t5_addr", 32'(rf_addr), 32'(exp_a));
                exp_a = exp_a + 3'd1;
            end
        end
        rf_busy = 1'b0;
        check_eq("t5_commits", 32'(n_commits - base), 32'd3);
        check_eq("t5_count0", 32'(count), 32'd0);
        check_eq("t5_rf4", 32'(rf_mem[4]), 32'h00A1);
        check_eq("t5_rf5", 32'(rf_mem[5]), 32'h00A2);
        check_eq("t5_rf6", 32'(rf_mem[6]), 32'h00A3);

`ifdef WB_BYPASS_EN
        // Forwarding picks the youngest match
        rf_busy = 1'b1;
        push(3'd3, 16'h0AAA);
        push(3'd3, 16'h0BBB);
        byp_addr = 3'd3;
        #1;
        check_eq("t6_hit", 32'(byp_hit), 32'd1);
        check_eq("t6_data", 32'(byp_data), 32'h0BBB);
        byp_addr = 3'd4;
        #1;
        check_eq("t6_miss", 32'(byp_hit), 32'd0);
        check_eq("t6_miss_data", 32'(byp_data), 32'd0);
        byp_addr = 3'd3;
        rf_busy  = 1'b0;
        tick();
        check_eq("t6_hit_q_over_s", 32'(byp_data), 32'h0BBB);
        tick();
        check_eq("t6_hit_strobe", 32'(byp_hit), 32'd1);
        check_eq("t6_data_strobe", 32'(byp_data), 32'h0BBB);
        tick();
        check_eq("t6_hit_done", 32'(byp_hit), 32'd0);
`endif

        // Reset mid-strobe with three still queued
        rf_busy = 1'b1;
        for (int k = 0; k < 4; k++) push(3'(k), 16'h2000 + 16'(k));
        rf_busy = 1'b0;
        tick();
        check_eq("t1_we_pre", 32'(rf_we), 32'd1);
        check_eq("t1_count_pre", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1_we", 32'(rf_we), 32'd0);
        check_eq("t1_addr", 32'(rf_addr), 32'd0);
        check_eq("t1_data", 32'(rf_wdata), 32'd0);
        check_eq("t1_count", 32'(count), 32'd0);
        check_eq("t1_pending", 32'(pending), 32'd0);
        base = n_commits;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_eq("t1_no_strobe", 32'(n_commits - base), 32'd0);
        check_eq("t1_we_after", 32'(rf_we), 32'd0);
        check_eq("t1_ready_after", 32'(wb_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
